// File: rtl/hx8352_pkg.sv
// Shared HX8352 definitions: register indices, RS levels and the register-reader state encoding.
package hx8352_pkg;

   localparam logic [7:0] REG_PRODUCT_ID = 8'h00;
   localparam logic [7:0] REG_DATA_RW    = 8'h22;

   localparam logic LCD_CMD  = 1'b0;
   localparam logic LCD_DATA = 1'b1;

   localparam int unsigned PhaseCntW = 8;

   typedef enum logic [3:0] {
      StIdle,
      StSetup,
      StIdxWrLow,
      StIdxWrHigh,
      StTurn,
      StDummyLow,
      StDummyHigh,
      StRdLow,
      StRdHigh,
      StDone
   } state_e;

   // A phase of N cycles loads N-1 so the terminal count lands on its last cycle.
   function automatic logic [PhaseCntW-1:0] phase_load(input int unsigned cycles);
      return PhaseCntW'(cycles - 1);
   endfunction

endpackage

// File: rtl/hx8352_reg_reader_if.sv
// Host handshake plus split LCD bus of the HX8352 register reader.
interface hx8352_reg_reader_if;

   logic        step;
   logic [7:0]  reg_index;
   logic        busy;
   logic        done;
   logic [15:0] data_out;
   logic        lcd_cs;
   logic        lcd_rs;
   logic        lcd_wr_n;
   logic        lcd_rd_n;
   logic [15:0] lcd_db_out;
   logic        lcd_db_oe;
   logic [15:0] lcd_db_in;

   modport slave (
      input  step, reg_index, lcd_db_in,
      output busy, done, data_out, lcd_cs, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db_out, lcd_db_oe
   );

   modport master (
      output step, reg_index, lcd_db_in,
      input  busy, done, data_out, lcd_cs, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db_out, lcd_db_oe
   );

endinterface

// File: rtl/hx8352_phase_counter.sv
// Loadable down-counter with terminal-count flag; times every strobe phase of the reader.
module hx8352_phase_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [Width-1:0] value_i,
   output logic             tc_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/hx8352_reg_reader.sv
// HX8352 register read sequencer: index write, bus turnaround, optional dummy read, real read.
module hx8352_reg_reader
   import hx8352_pkg::*;
#(
   parameter int unsigned T_WR_LOW   = 2,
   parameter int unsigned T_WR_HIGH  = 2,
   parameter int unsigned T_RD_LOW   = 4,
   parameter int unsigned T_RD_HIGH  = 2,
   parameter int unsigned DUMMY_READ = 1
) (
   input logic                clk,
   input logic                rst,
   hx8352_reg_reader_if.slave bus
);

   state_e                 state_q, state_d;
   logic [7:0]             idx_q, idx_d;
   logic                   cnt_load;
   logic [PhaseCntW-1:0]   cnt_val;
   logic                   cnt_tc;
   logic                   sample;
   logic                   oe_d;

   logic                   cs_q, rs_q, wr_n_q, rd_n_q, oe_q, busy_q, done_q;
   logic [15:0]            db_out_q, data_out_q;

   hx8352_phase_counter #(
      .Width(PhaseCntW)
   ) u_phase_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load),
      .value_i(cnt_val),
      .tc_o   (cnt_tc)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      unique case (state_q)
         StIdle: begin
            if (bus.step) begin
               state_d = StSetup;
               idx_d   = bus.reg_index;
            end
         end
         StSetup: begin
            state_d  = StIdxWrLow;
            cnt_load = 1'b1;
            cnt_val  = phase_load(T_WR_LOW);
         end
         StIdxWrLow: begin
            if (cnt_tc) begin
               state_d  = StIdxWrHigh;
               cnt_load = 1'b1;
               cnt_val  = phase_load(T_WR_HIGH);
            end
         end
         StIdxWrHigh: begin
            if (cnt_tc) begin
               state_d = StTurn;
            end
         end
         StTurn: begin
            state_d  = (DUMMY_READ != 0) ? StDummyLow : StRdLow;
            cnt_load = 1'b1;
            cnt_val  = phase_load(T_RD_LOW);
         end
         StDummyLow: begin
            if (cnt_tc) begin
               state_d  = StDummyHigh;
               cnt_load = 1'b1;
               cnt_val  = phase_load(T_RD_HIGH);
            end
         end
         StDummyHigh: begin
            if (cnt_tc) begin
               state_d  = StRdLow;
               cnt_load = 1'b1;
               cnt_val  = phase_load(T_RD_LOW);
            end
         end
         StRdLow: begin
            if (cnt_tc) begin
               state_d  = StRdHigh;
               cnt_load = 1'b1;
               cnt_val  = phase_load(T_RD_HIGH);
            end
         end
         StRdHigh: begin
            if (cnt_tc) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // The panel drives valid data by the end of the real read's low phase.
   assign sample = (state_q == StRdLow) && cnt_tc;
   assign oe_d   = (state_d == StSetup) || (state_d == StIdxWrLow) || (state_d == StIdxWrHigh);

   // Outputs are decoded from the next state so they are registered yet aligned with it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         cs_q       <= 1'b1;
         rs_q       <= LCD_CMD;
         wr_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         oe_q       <= 1'b0;
         db_out_q   <= '0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cs_q     <= (state_d == StIdle) || (state_d == StDone);
         rs_q     <= (state_d inside {StTurn, StDummyLow, StDummyHigh, StRdLow, StRdHigh}) ?
                     LCD_DATA : LCD_CMD;
         wr_n_q   <= (state_d != StIdxWrLow);
         rd_n_q   <= !((state_d == StDummyLow) || (state_d == StRdLow));
         oe_q     <= oe_d;
         db_out_q <= oe_d ? {8'h00, idx_d} : 16'h0000;
         busy_q   <= (state_d != StIdle);
         done_q   <= (state_d == StDone);
         if (sample) begin
            data_out_q <= bus.lcd_db_in;
         end
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.data_out   = data_out_q;
   assign bus.lcd_cs     = cs_q;
   assign bus.lcd_rs     = rs_q;
   assign bus.lcd_wr_n   = wr_n_q;
   assign bus.lcd_rd_n   = rd_n_q;
   assign bus.lcd_db_out = db_out_q;
   assign bus.lcd_db_oe  = oe_q;

endmodule

// File: tb/tb_hx8352_reg_reader.sv
// Bench for hx8352_reg_reader: one DUT with a dummy read, one without, behavioural panel models.
module tb_hx8352_reg_reader;
   import hx8352_pkg::*;

   localparam int unsigned TWL = 2;
   localparam int unsigned TWH = 2;
   localparam int unsigned TRL = 4;
   localparam int unsigned TRH = 2;

   typedef struct packed {
      logic        cs, rs, wr_n, rd_n, oe, busy, done;
      logic [15:0] db_out, data_out;
   } obs_t;

   typedef struct {
      int          d;
      logic [7:0]  idx;
      logic [15:0] resp;
      bit          hammer;
      bit          leave;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   hx8352_reg_reader_if if0 ();
   hx8352_reg_reader_if if1 ();

   hx8352_reg_reader #(
      .T_WR_LOW(TWL), .T_WR_HIGH(TWH), .T_RD_LOW(TRL), .T_RD_HIGH(TRH), .DUMMY_READ(1)
   ) u_dut0 (
      .clk(clk), .rst(rst0), .bus(if0)
   );

   hx8352_reg_reader #(
      .T_WR_LOW(TWL), .T_WR_HIGH(TWH), .T_RD_LOW(TRL), .T_RD_HIGH(TRH), .DUMMY_READ(0)
   ) u_dut1 (
      .clk(clk), .rst(rst1), .bus(if1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   obs_t obs0, obs1, s;
   int   cur = 0;
   assign obs0 = '{if0.lcd_cs, if0.lcd_rs, if0.lcd_wr_n, if0.lcd_rd_n, if0.lcd_db_oe,
                   if0.busy, if0.done, if0.lcd_db_out, if0.data_out};
   assign obs1 = '{if1.lcd_cs, if1.lcd_rs, if1.lcd_wr_n, if1.lcd_rd_n, if1.lcd_db_oe,
                   if1.busy, if1.done, if1.lcd_db_out, if1.data_out};
   assign s = (cur == 0) ? obs0 : obs1;

   // Panel model: the first read pulse of a DUT0 transfer returns DEAD, later ones the register;
   // outside a read strobe the bus carries noise so mistimed sampling shows up.
   logic [15:0] resp0 = 16'h0, resp1 = 16'h0, noise = 16'h0;
   int          pulses0 = 0;
   always @(posedge clk) noise <= 16'($urandom);
   always @(posedge if0.lcd_rd_n or posedge if0.lcd_cs) begin
      if (if0.lcd_cs) pulses0 = 0;
      else            pulses0 = pulses0 + 1;
   end
   always_comb if0.lcd_db_in = if0.lcd_rd_n ? noise : ((pulses0 == 0) ? 16'hDEAD : resp0);
   always_comb if1.lcd_db_in = if1.lcd_rd_n ? noise : resp1;

   // Continuous invariants on both DUTs.
   logic        rst_e [2];
   logic        prev_rdn [2];
   logic [15:0] prev_data [2];
   always @(posedge clk) begin
      rst_e[0] <= rst0;
      rst_e[1] <= rst1;
   end

   task automatic monitor(input int d, input obs_t o);
      check("inv_oe_and_rd", 32'(o.oe && !o.rd_n), 32'(0));
      check("inv_wr_and_rd", 32'(!o.wr_n && !o.rd_n), 32'(0));
      if (o.busy && !o.done) check("cs_low_in_transfer", 32'(o.cs), 32'(0));
      if (rst_e[d] && (o.data_out != prev_data[d]))
         check("sample_only_at_rd_low_exit", 32'({prev_rdn[d], o.rd_n}), 32'(2'b01));
      prev_data[d] = o.data_out;
      prev_rdn[d]  = o.rd_n;
   endtask

   always @(negedge clk) begin
      monitor(0, obs0);
      monitor(1, obs1);
   end

   task automatic drive(input int d, input logic stp, input logic [7:0] idx);
      if (d == 0) begin
         if0.step = stp; if0.reg_index = idx;
      end else begin
         if1.step = stp; if1.reg_index = idx;
      end
   endtask

   // Cycle index (1 = first cycle after the accepting edge) in which DONE appears:
   // SETUP, write low, write high, TURN, optional dummy pulse, real pulse, then DONE.
   function automatic int done_cycle(input int dummy);
      return 1 + TWL + TWH + 1 + dummy * (TRL + TRH) + TRL + TRH + 1;
   endfunction

   task automatic do_read(input int d, input logic [7:0] idx, input logic [15:0] resp,
                          input bit hammer, input bit chained, input bit leave);
      int lat, dummy, done_at, n_done, n_busy, n_rd, n_wr, n_oe, db_bad;
      logic prev_rd, prev_wr;
      bit seen;
      cur   = d;
      dummy = (d == 0) ? 1 : 0;
      lat   = done_cycle(dummy);
      if (d == 0) resp0 = resp;
      else        resp1 = resp;
      @(negedge clk);
      if (chained) check("step_in_done_ignored", 32'(s.busy), 32'(0));
      drive(d, 1'b1, idx);
      @(posedge clk);
      done_at = -1; n_done = 0; n_busy = 0; n_rd = 0; n_wr = 0; n_oe = 0; db_bad = 0;
      prev_rd = 1'b1; prev_wr = 1'b1; seen = 1'b0;
      for (int c = 1; c <= lat + 3; c++) begin
         @(negedge clk);
         if (s.busy) n_busy++;
         if (!s.rd_n && prev_rd) n_rd++;
         if (!s.wr_n && prev_wr) n_wr++;
         prev_rd = s.rd_n;
         prev_wr = s.wr_n;
         if (s.oe) begin
            n_oe++;
            if (s.db_out != {8'h00, idx}) db_bad++;
         end
         if (s.done) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
         if (leave && s.done) begin
            drive(d, 1'b1, 8'($urandom));
            break;
         end
         drive(d, hammer && !seen, 8'($urandom));
         if (s.done) seen = 1'b1;
      end
      check("done_cycle", 32'(done_at), 32'(lat));
      check("done_pulses", 32'(n_done), 32'(1));
      check("busy_cycles", 32'(n_busy), 32'(lat));
      check("rd_pulses", 32'(n_rd), 32'(1 + dummy));
      check("wr_pulses", 32'(n_wr), 32'(1));
      check("oe_cycles", 32'(n_oe), 32'(1 + TWL + TWH));
      check("db_out_index", 32'(db_bad), 32'(0));
      check("data_out", 32'(s.data_out), 32'(resp));
   endtask

   task automatic reset_mid();
      int  rl2;
      bit  saw_done;
      cur = 0;
      resp0 = 16'hA5C3;
      check("data_out_before_abort_nonzero", 32'(obs0.data_out != 16'h0), 32'(1));
      @(negedge clk);
      drive(0, 1'b1, REG_DATA_RW);
      @(posedge clk);
      rl2 = 1 + TWL + TWH + 1 + (TRL + TRH) + 2;
      saw_done = 1'b0;
      for (int c = 1; c <= rl2; c++) begin
         @(negedge clk);
         drive(0, 1'b0, 8'($urandom));
         if (obs0.done) saw_done = 1'b1;
      end
      check("second_rd_low_reached", 32'(obs0.rd_n), 32'(0));
      rst0 = 1'b0;
      @(negedge clk);
      check("abort_cs", 32'(obs0.cs), 32'(1));
      check("abort_rd_n", 32'(obs0.rd_n), 32'(1));
      check("abort_oe", 32'(obs0.oe), 32'(0));
      check("abort_data_out", 32'(obs0.data_out), 32'(0));
      if (obs0.done) saw_done = 1'b1;
      rst0 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (obs0.done) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'(0));
      check("abort_stays_idle", 32'(obs0.busy), 32'(0));
   endtask

   vec_t tbl [7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{0, REG_PRODUCT_ID, 16'h0052, 1'b0, 1'b0};
      tbl[1] = '{0, REG_PRODUCT_ID, 16'h0052, 1'b1, 1'b0};
      tbl[2] = '{1, REG_DATA_RW,    16'h1234, 1'b0, 1'b0};
      tbl[3] = '{0, REG_PRODUCT_ID, 16'h0052, 1'b0, 1'b1};
      tbl[4] = '{0, REG_DATA_RW,    16'hBEEF, 1'b0, 1'b0};
      tbl[5] = '{1, REG_PRODUCT_ID, 16'h0052, 1'b1, 1'b1};
      tbl[6] = '{1, REG_DATA_RW,    16'h1234, 1'b0, 1'b0};

      rst0 = 1'b0; rst1 = 1'b0;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b1, 8'h5A);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl0", 32'({obs0.cs, obs0.rs, obs0.wr_n, obs0.rd_n, obs0.oe, obs0.busy,
                               obs0.done}), 32'(7'b1011000));
      check("reset_db0", 32'({obs0.db_out, obs0.data_out}), 32'(0));
      check("reset_ctrl1", 32'({obs1.cs, obs1.rs, obs1.wr_n, obs1.rd_n, obs1.oe, obs1.busy,
                               obs1.done}), 32'(7'b1011000));
      check("reset_db1", 32'({obs1.db_out, obs1.data_out}), 32'(0));
      drive(1, 1'b0, 8'h00);
      rst0 = 1'b1; rst1 = 1'b1;

      for (int i = 0; i < 7; i++) begin
         do_read(tbl[i].d, tbl[i].idx, tbl[i].resp, tbl[i].hammer,
                 (i > 0) && tbl[i-1].leave, tbl[i].leave);
      end

      reset_mid();

      for (int i = 0; i < 12; i++) begin
         do_read(int'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
